// File: rtl/dcm_prog_responder.sv
// rtl/dcm_prog_responder.sv - DCM_CLKGEN-style PROGEN/PROGDATA/PROGDONE responder; optional counters via DCM_PROG_STATS_EN
module dcm_prog_responder #(
    parameter logic [7:0]  INITIAL_M_S1 = 8'd15,
    parameter logic [7:0]  INITIAL_D_S1 = 8'd7,
    parameter int unsigned GO_LATENCY   = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dcm_prog_en,
    input  logic        dcm_prog_data,
    output logic        dcm_prog_done,
    output logic [7:0]  dcm_m_s1,
    output logic [7:0]  dcm_d_s1,
    output logic        cfg_update,
`ifdef DCM_PROG_STATS_EN
    output logic [15:0] go_count,
    output logic [15:0] err_count,
`endif
    output logic        proto_error
);

    localparam logic [15:0] LP_GO_LAT = 16'(GO_LATENCY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_SHIFT,
        S_TAIL,
        S_GO_CHK,
        S_GO_WAIT
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic        r_tgt_m;
    logic [7:0]  r_pend_m;
    logic [7:0]  r_pend_d;
    logic        r_pend_m_vld;
    logic        r_pend_d_vld;
    logic [15:0] r_wait_cnt;
    logic        r_done;
    logic [7:0]  r_m_s1;
    logic [7:0]  r_d_s1;
    logic        r_cfg_update;
    logic        r_proto_error;

    logic        w_err;
    logic        w_sel;
    logic        w_shift;
    logic        w_commit;
    logic        w_go_ok;
    logic        w_go_bad;
    logic        w_wait_end;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Decode one protocol bit per cycle into next state and datapath strobes
    always_comb begin
        w_next     = r_state;
        w_err      = 1'b0;
        w_sel      = 1'b0;
        w_shift    = 1'b0;
        w_commit   = 1'b0;
        w_go_ok    = 1'b0;
        w_go_bad   = 1'b0;
        w_wait_end = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (dcm_prog_en) begin
                    w_next = dcm_prog_data ? S_CMD : S_GO_CHK;
                end
            end
            S_CMD: begin
                if (dcm_prog_en) begin
                    w_sel  = 1'b1;
                    w_next = S_SHIFT;
                end else begin
                    w_err  = 1'b1;
                    w_next = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (dcm_prog_en) begin
                    w_shift = 1'b1;
                    if (r_bit_cnt == 3'd7) begin
                        w_next = S_TAIL;
                    end
                end else begin
                    w_err  = 1'b1;
                    w_next = S_IDLE;
                end
            end
            S_TAIL: begin
                if (!dcm_prog_en) begin
                    w_commit = 1'b1;
                end else begin
                    w_err = 1'b1;
                end
                w_next = S_IDLE;
            end
            S_GO_CHK: begin
                w_next = S_IDLE;
                if (dcm_prog_en) begin
                    w_err = 1'b1;
                end else if (r_pend_m_vld && (r_pend_m == 8'd0)) begin
                    // M=1 cannot be programmed: reject the whole GO
                    w_err    = 1'b1;
                    w_go_bad = 1'b1;
                end else begin
                    w_go_ok = 1'b1;
                    w_next  = S_GO_WAIT;
                end
            end
            S_GO_WAIT: begin
                // en during the settle interval is flagged but otherwise ignored
                w_err = dcm_prog_en;
                if (r_wait_cnt == 16'd1) begin
                    w_wait_end = 1'b1;
                    w_next     = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Serial shifter: LSB arrives first, so new bits enter at the top
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'd0;
            r_tgt_m   <= 1'b0;
        end else begin
            if (w_sel) begin
                r_tgt_m   <= dcm_prog_data;
                r_bit_cnt <= 3'd0;
            end
            if (w_shift) begin
                r_shift   <= {dcm_prog_data, r_shift[7:1]};
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
        end
    end

    // Pending values: written at load tail, consumed or dropped by GO check
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend_m     <= 8'd0;
            r_pend_d     <= 8'd0;
            r_pend_m_vld <= 1'b0;
            r_pend_d_vld <= 1'b0;
        end else begin
            if (w_commit && r_tgt_m) begin
                r_pend_m     <= r_shift;
                r_pend_m_vld <= 1'b1;
            end
            if (w_commit && !r_tgt_m) begin
                r_pend_d     <= r_shift;
                r_pend_d_vld <= 1'b1;
            end
            if (w_go_ok || w_go_bad) begin
                r_pend_m_vld <= 1'b0;
                r_pend_d_vld <= 1'b0;
            end
        end
    end

    // Active values change only when a GO is accepted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_m_s1 <= INITIAL_M_S1;
            r_d_s1 <= INITIAL_D_S1;
        end else if (w_go_ok) begin
            if (r_pend_m_vld) begin
                r_m_s1 <= r_pend_m;
            end
            if (r_pend_d_vld) begin
                r_d_s1 <= r_pend_d;
            end
        end
    end

    // Settle interval: done low for GO_LATENCY cycles, then update pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait_cnt   <= 16'd0;
            r_done       <= 1'b1;
            r_cfg_update <= 1'b0;
        end else begin
            r_cfg_update <= 1'b0;
            if (w_go_ok) begin
                r_wait_cnt <= LP_GO_LAT;
                r_done     <= 1'b0;
            end else if (r_state == S_GO_WAIT) begin
                r_wait_cnt <= r_wait_cnt - 16'd1;
                if (w_wait_end) begin
                    r_done       <= 1'b1;
                    r_cfg_update <= 1'b1;
                end
            end
        end
    end

    // Single-cycle protocol violation flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_proto_error <= 1'b0;
        end else begin
            r_proto_error <= w_err;
        end
    end

`ifdef DCM_PROG_STATS_EN
    logic [15:0] r_go_count;
    logic [15:0] r_err_count;

    // Saturating counters of accepted GOs and error pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_go_count  <= 16'd0;
            r_err_count <= 16'd0;
        end else begin
            if (w_go_ok && (r_go_count != 16'hFFFF)) begin
                r_go_count <= r_go_count + 16'd1;
            end
            if (w_err && (r_err_count != 16'hFFFF)) begin
                r_err_count <= r_err_count + 16'd1;
            end
        end
    end

    assign go_count  = r_go_count;
    assign err_count = r_err_count;
`endif

    assign dcm_prog_done = r_done;
    assign dcm_m_s1      = r_m_s1;
    assign dcm_d_s1      = r_d_s1;
    assign cfg_update    = r_cfg_update;
    assign proto_error   = r_proto_error;

endmodule
